// File: rtl/fft_bitrev_framer.sv
// Ping-pong frame buffer ahead of the FFT core: collects N samples per bank and
// replays each bank in bit-reversed index order, closing early or late frames cleanly.
module fft_bitrev_framer #(
  parameter int DATA_W = 50,
  parameter int N      = 8
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic              frame_err_o,
  output logic [3:0]        dbg_bank_state_o
);

  localparam int LOG2N = $clog2(N);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  typedef logic [LOG2N-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(N - 1);

  bank_state_e       st_q [2];
  bank_state_e       st_d [2];
  logic [N-1:0]      vld_q [2];
  logic [N-1:0]      vld_d [2];
  logic              wb_q, wb_d;
  logic              rb_q, rb_d;
  idx_t              wr_idx_q, wr_idx_d;
  idx_t              rd_idx_q, rd_idx_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mem_q [2][N];

  logic              wr_fire;
  logic              rd_fire;
  logic              wr_close;
  idx_t              rd_addr;

  function automatic idx_t bitrev(input idx_t i);
    idx_t r;
    r = '0;
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = i[LOG2N-1-b];
    end
    return r;
  endfunction

  // Both ports: a transfer happens on every rising edge where valid and ready
  // are both high; valid never depends on ready, and a source never retracts
  // m_tvalid or changes m_tdata/m_tlast until the transfer completes.
  assign s_tready = !reset && (st_q[wb_q] == EMPTY || st_q[wb_q] == FILLING);
  assign m_tvalid = (st_q[rb_q] == FULL) || (st_q[rb_q] == DRAINING);
  assign rd_addr  = bitrev(rd_idx_q);
  assign m_tdata  = (m_tvalid && vld_q[rb_q][rd_addr]) ? mem_q[rb_q][rd_addr] : '0;
  assign m_tlast  = m_tvalid && (rd_idx_q == LAST_IDX);

  assign wr_fire  = s_tvalid && s_tready;
  assign rd_fire  = m_tvalid && m_tready;
  assign wr_close = (wr_idx_q == LAST_IDX) || s_tlast;

  assign frame_err_o      = err_q;
  assign dbg_bank_state_o = {st_q[1], st_q[0]};

  // Write and read never target the same bank in one cycle: their state sets are disjoint.
  always_comb begin
    st_d     = st_q;
    vld_d    = vld_q;
    wb_d     = wb_q;
    rb_d     = rb_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    err_d    = 1'b0;

    if (wr_fire) begin
      if (wr_idx_q == '0) begin
        vld_d[wb_q] = '0;
      end
      vld_d[wb_q][wr_idx_q] = 1'b1;
      if (wr_close) begin
        st_d[wb_q] = FULL;
        wr_idx_d   = '0;
        wb_d       = ~wb_q;
        err_d      = (wr_idx_q == LAST_IDX) != s_tlast;
      end else begin
        st_d[wb_q] = FILLING;
        wr_idx_d   = wr_idx_q + 1'b1;
      end
    end

    if (rd_fire) begin
      if (m_tlast) begin
        st_d[rb_q] = EMPTY;
        rd_idx_d   = '0;
        rb_d       = ~rb_q;
      end else begin
        st_d[rb_q] = DRAINING;
        rd_idx_d   = rd_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= EMPTY;
        vld_q[i] <= '0;
      end
      wb_q     <= 1'b0;
      rb_q     <= 1'b0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= st_d[i];
        vld_q[i] <= vld_d[i];
      end
      wb_q     <= wb_d;
      rb_q     <= rb_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      err_q    <= err_d;
    end
  end

  // Sample storage needs no reset: the valid mask hides stale entries.
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      mem_q[wb_q][wr_idx_q] <= s_tdata;
    end
  end

endmodule
